// File: rtl/inst_decoder.sv
// rtl/inst_decoder.sv - recovers letters from the shifted instruction bus and decodes ATM keywords.
// Optional INST_DBG_EN adds dbg_word/dbg_words observation outputs.
module inst_decoder #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMER_W        = 8
) (
  input  logic        sec_clock,
  input  logic        rst,
  input  logic [39:0] instruction,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic        cmd_err,
  output logic [1:0]  err_code,
  output logic [3:0]  char_count,
  output logic        busy
`ifdef INST_DBG_EN
  ,
  output logic [39:0] dbg_word,
  output logic [7:0]  dbg_words
`endif
);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

  localparam logic [1:0] E_UNKNOWN  = 2'd0;
  localparam logic [1:0] E_BADCHAR  = 2'd1;
  localparam logic [1:0] E_OVERFLOW = 2'd2;
  localparam logic [1:0] E_BREAK    = 2'd3;

  // Keyword letters packed with letter i at bits [5*i +: 5].
  localparam logic [39:0] KW_WORD [4] = '{
    {5'd18, 5'd5,  5'd6,  5'd19, 5'd14, 5'd1,  5'd18, 5'd20},  // TRANSFER
    {5'd0,  5'd20, 5'd9,  5'd19, 5'd15, 5'd16, 5'd5,  5'd4 },  // DEPOSIT
    {5'd23, 5'd1,  5'd18, 5'd4,  5'd8,  5'd20, 5'd9,  5'd23},  // WITHDRAW
    {5'd0,  5'd5,  5'd3,  5'd14, 5'd1,  5'd12, 5'd1,  5'd2 }   // BALANCE
  };
  localparam logic [3:0] KW_LEN [4] = '{4'd8, 4'd7, 4'd8, 4'd7};

  state_t             state, state_n;
  logic [39:0]        prev;
  logic [3:0]         mask, mask_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic               valid_n, err_n;
  logic [2:0]         code_n;
  logic [1:0]         ecode_n;
  logic [3:0]         count_n;

  logic       any_evt, shift_evt, brk_evt, timeout;
  logic [4:0] ch;
  logic       is_letter, is_bad;
  logic       hit;
  logic [2:0] hit_code;

  assign any_evt   = (instruction != prev);
  assign shift_evt = any_evt && (instruction[39:5] == prev[34:0]);
  assign brk_evt   = any_evt && !shift_evt;
  assign ch        = instruction[4:0];
  assign is_letter = (ch != 5'd0) && (ch <= 5'd26);
  assign is_bad    = (ch > 5'd26);
  assign timeout   = (state != IDLE) && !any_evt && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign busy      = (state != IDLE);

  function automatic logic [3:0] letter_mask(input logic [3:0] m, input logic [2:0] idx,
                                             input logic [4:0] c);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      r[k] = m[k] && ({1'b0, idx} < KW_LEN[k]) && (KW_WORD[k][5*idx +: 5] == c);
    end
    return r;
  endfunction

  // Keyword lengths are distinct per prefix, so at most one bit qualifies.
  always_comb begin
    hit      = 1'b0;
    hit_code = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (mask[k] && (KW_LEN[k] == char_count)) begin
        hit      = 1'b1;
        hit_code = 3'(k + 1);
      end
    end
  end

  always_ff @(posedge sec_clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (shift_evt && is_letter) state_n = RECV;
      RECV: begin
        if (shift_evt) begin
          if (ch == 5'd0)                        state_n = IDLE;
          else if (is_bad || char_count == 4'd8) state_n = FLUSH;
        end else if (brk_evt || timeout) begin
          state_n = IDLE;
        end
      end
      FLUSH: if ((shift_evt && ch == 5'd0) || brk_evt || timeout) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    valid_n = 1'b0;
    err_n   = 1'b0;
    code_n  = cmd_code;
    ecode_n = err_code;
    count_n = char_count;
    mask_n  = mask;
    timer_n = (state_n == IDLE || any_evt) ? '0 : timer + 1'b1;
    case (state)
      IDLE: begin
        if (shift_evt && is_letter) begin
          mask_n  = letter_mask(4'hf, 3'd0, ch);
          count_n = 4'd1;
        end else if (shift_evt && is_bad) begin
          err_n   = 1'b1;
          ecode_n = E_BADCHAR;
        end
      end
      RECV: begin
        if (shift_evt) begin
          if (ch == 5'd0) begin
            if (hit) begin
              valid_n = 1'b1;
              code_n  = hit_code;
            end else begin
              err_n   = 1'b1;
              ecode_n = E_UNKNOWN;
            end
            count_n = 4'd0;
          end else if (is_bad) begin
            err_n   = 1'b1;
            ecode_n = E_BADCHAR;
            count_n = 4'd0;
          end else if (char_count == 4'd8) begin
            err_n   = 1'b1;
            ecode_n = E_OVERFLOW;
            count_n = 4'd0;
          end else begin
            mask_n  = letter_mask(mask, char_count[2:0], ch);
            count_n = char_count + 4'd1;
          end
        end else if (brk_evt || timeout) begin
          err_n   = 1'b1;
          ecode_n = E_BREAK;
          count_n = 4'd0;
        end
      end
      FLUSH:   count_n = 4'd0;
      default: count_n = 4'd0;
    endcase
  end

  always_ff @(posedge sec_clock or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      mask       <= '0;
      timer      <= '0;
      cmd_valid  <= 1'b0;
      cmd_err    <= 1'b0;
      cmd_code   <= 3'd0;
      err_code   <= 2'd0;
      char_count <= 4'd0;
    end else begin
      prev       <= instruction;
      mask       <= mask_n;
      timer      <= timer_n;
      cmd_valid  <= valid_n;
      cmd_err    <= err_n;
      cmd_code   <= code_n;
      err_code   <= ecode_n;
      char_count <= count_n;
    end
  end

`ifdef INST_DBG_EN
  always_ff @(posedge sec_clock or posedge rst) begin
    if (rst) begin
      dbg_word  <= '0;
      dbg_words <= '0;
    end else if (valid_n || err_n) begin
      dbg_word <= instruction;
      if (dbg_words != 8'hff) dbg_words <= dbg_words + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_decoder.sv
// tb/tb_inst_decoder.sv - scoreboard bench for inst_decoder against a string-level keyword model.
module tb_inst_decoder;
  localparam int TO = 16;

  logic        sec_clock = 1'b0;
  logic        rst = 1'b0;
  logic [39:0] instruction = '0;
  logic        cmd_valid, cmd_err, busy;
  logic [2:0]  cmd_code;
  logic [1:0]  err_code;
  logic [3:0]  char_count;
`ifdef INST_DBG_EN
  logic [39:0] dbg_word;
  logic [7:0]  dbg_words;
`endif

  inst_decoder #(.TIMEOUT_CYCLES(TO), .TIMER_W(8)) dut (
    .sec_clock(sec_clock), .rst(rst), .instruction(instruction),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_err(cmd_err),
    .err_code(err_code), .char_count(char_count), .busy(busy)
`ifdef INST_DBG_EN
    , .dbg_word(dbg_word), .dbg_words(dbg_words)
`endif
  );

  always #5 sec_clock = ~sec_clock;

  typedef struct {
    bit is_err;
    int code;
    int cyc;
  } exp_t;

  exp_t  sbq[$];
  int    checks = 0, errors = 0, cyc = 0;
  bit    in_rst = 1'b1;
  string kws[4] = '{"TRANSFER", "DEPOSIT", "WITHDRAW", "BALANCE"};

  // Reference model: 0 idle, 1 receiving, 2 flushing; the word is kept as text.
  logic [39:0] mprev = '0;
  int    mode = 0, quiet = 0, m_count = 0, m_code = 0, m_ecode = 0;
  bit    m_busy = 1'b0;
  string word = "";

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input bit is_err, input int code);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.cyc    = cyc;
    sbq.push_back(e);
    if (is_err) m_ecode = code;
    else        m_code  = code;
  endtask

  task automatic model_step(input logic [39:0] v);
    bit sh, br;
    int c, found;
    sh = (v != mprev) && (v[39:5] == mprev[34:0]);
    br = (v != mprev) && !sh;
    c  = int'(v[4:0]);
    mprev = v;
    case (mode)
      0: begin
        if (sh && c >= 1 && c <= 26) begin
          word = string'(8'(c + 64)); mode = 1; quiet = 0;
        end else if (sh && c > 26) expect_pulse(1, 1);
      end
      1: begin
        if (sh) begin
          quiet = 0;
          if (c == 0) begin
            found = 0;
            for (int k = 0; k < 4; k++) if (word == kws[k]) found = k + 1;
            if (found != 0) expect_pulse(0, found);
            else            expect_pulse(1, 0);
            mode = 0;
          end else if (c > 26) begin
            expect_pulse(1, 1); mode = 2;
          end else if (word.len() == 8) begin
            expect_pulse(1, 2); mode = 2;
          end else begin
            word = {word, string'(8'(c + 64))};
          end
        end else if (br) begin
          expect_pulse(1, 3); mode = 0;
        end else begin
          quiet++;
          if (quiet == TO) begin expect_pulse(1, 3); mode = 0; end
        end
      end
      default: begin
        if ((sh && c == 0) || br) mode = 0;
        else if (sh) quiet = 0;
        else begin
          quiet++;
          if (quiet == TO) mode = 0;
        end
      end
    endcase
    if (mode != 1) word = "";
    m_count = (mode == 1) ? word.len() : 0;
    m_busy  = (mode != 0);
  endtask

  task automatic step(input logic [39:0] v);
    instruction = v;
    @(posedge sec_clock);
    cyc++;
    model_step(v);
    @(negedge sec_clock);
  endtask

  task automatic shift(input int c);
    step({instruction[34:0], 5'(c)});
  endtask

  task automatic send_word(input string s, input bit term);
    for (int i = 0; i < s.len(); i++) shift(int'(s[i]) - 64);
    if (term) shift(0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(instruction);
  endtask

  always @(negedge sec_clock) begin
    exp_t e;
    if (!in_rst) begin
      if (cmd_valid || cmd_err) begin
        if (sbq.size() == 0) check("spurious_pulse", 1, 0);
        else begin
          e = sbq.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_is_err", int'(cmd_err), int'(e.is_err));
          check("both_pulses", int'(cmd_valid && cmd_err), 0);
          if (e.is_err) check("err_code", int'(err_code), e.code);
          else          check("cmd_code", int'(cmd_code), e.code);
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        check("missing_pulse", 0, 1);
      end
      check("char_count", int'(char_count), m_count);
      check("busy", int'(busy), int'(m_busy));
      check("held_cmd_code", int'(cmd_code), m_code);
      check("held_err_code", int'(err_code), m_ecode);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_valid"}, int'(cmd_valid), 0);
    check({tag, "_cmd_err"}, int'(cmd_err), 0);
    check({tag, "_cmd_code"}, int'(cmd_code), 0);
    check({tag, "_err_code"}, int'(err_code), 0);
    check({tag, "_char_count"}, int'(char_count), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic model_reset();
    mprev = '0; mode = 0; quiet = 0; word = "";
    m_count = 0; m_busy = 0; m_code = 0; m_ecode = 0;
    sbq.delete();
  endtask

  initial begin
    logic [63:0] r64;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge sec_clock);
    @(negedge sec_clock);
    rst = 1'b0;
    in_rst = 1'b0;
    @(negedge sec_clock);

    send_word("TRANSFER", 1);
    send_word("DEPOSIT", 1);
    send_word("BALANCE", 1);
    send_word("TRANS", 1);
    send_word("TRANSFER", 1);
    shift(20); shift(28); send_word("RA", 1);
    send_word("WITHDRAW", 1);
    send_word("TRA", 0); step(40'd0);
    shift(20); idle(TO + 2);
    send_word("TRANSFERX", 1);
    shift(0); shift(0);

    send_word("TRAN", 0);
    #2 rst = 1'b1;
    in_rst = 1'b1;
    #1 check_reset_outputs("midword_reset");
    instruction = '0;
    @(posedge sec_clock);
    @(negedge sec_clock);
    #2 rst = 1'b0;
    model_reset();
    in_rst = 1'b0;
    @(negedge sec_clock);
    send_word("TRANSFER", 1);

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: send_word(kws[$urandom_range(0, 3)], $urandom_range(0, 3) != 0);
        4, 9:       shift($urandom_range(1, 26));
        5:          shift(0);
        6:          shift($urandom_range(27, 31));
        7: begin
          r64 = {$urandom, $urandom};
          step(r64[39:0]);
        end
        default:    idle($urandom_range(1, 20));
      endcase
    end

    idle(TO + 3);
    check("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
